// File: rtl/huff_pkg.sv
// Shared types for the Huffman code table: default field widths, FSM states
// and the {len, code} entry stored per symbol.
package huff_pkg;

  localparam int DEF_LEN_W  = 6;
  localparam int DEF_CODE_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } tbl_state_t;

  typedef struct packed {
    logic [DEF_LEN_W-1:0]  len;
    logic [DEF_CODE_W-1:0] code;
  } entry_t;

endpackage

// File: rtl/huff_code_table_if.sv
// Writer/reader bus of the code table: clear control, one write port and
// NUM_RD flattened read ports, plus status back to the code builder.
interface huff_code_table_if #(
  parameter int AW     = 8,
  parameter int LEN_W  = 6,
  parameter int CODE_W = 16,
  parameter int NUM_RD = 2
);

  logic                     clr_start;
  logic                     busy;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [LEN_W-1:0]         wr_len;
  logic [CODE_W-1:0]        wr_code;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD-1:0]        rd_valid;
  logic [NUM_RD*LEN_W-1:0]  rd_len;
  logic [NUM_RD*CODE_W-1:0] rd_code;
  logic [AW:0]              nz_count;

  modport master (
    output clr_start, wr_en, wr_addr, wr_len, wr_code, rd_en, rd_addr,
    input  busy, rd_valid, rd_len, rd_code, nz_count
  );

  modport slave (
    input  clr_start, wr_en, wr_addr, wr_len, wr_code, rd_en, rd_addr,
    output busy, rd_valid, rd_len, rd_code, nz_count
  );

endinterface

// File: rtl/huff_tbl_rd_port.sv
// One registered read port: write-first bypass, zero data while the table is
// being cleared, and output registers that hold when the port is not strobed.
module huff_tbl_rd_port
  import huff_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  entry_t        mem_entry,
  input  logic          clearing,
  input  logic          wr_acc,
  input  logic [AW-1:0] wr_addr,
  input  entry_t        wr_entry,
  output logic          rd_valid,
  output entry_t        rd_data
);

  entry_t sel_entry;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_entry = mem_entry;
    if (clearing) begin
      sel_entry = '0;
    end else if (wr_acc && (rd_addr == wr_addr)) begin
      sel_entry = wr_entry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= sel_entry;
      end
    end
  end

endmodule

// File: rtl/huff_code_table.sv
// Symbol -> {code length, codeword} table with a hardware clear sweep,
// NUM_RD registered write-first read ports and a live used-symbol count.
module huff_code_table
  import huff_pkg::*;
#(
  parameter int REG_NUM = 256,
  parameter int NUM_RD  = 2,
  // Field widths must match the entry_t layout in huff_pkg.
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CODE_W  = DEF_CODE_W
) (
  input logic              clk,
  input logic              rst,
  huff_code_table_if.slave bus
);

  localparam int            AW       = $clog2(REG_NUM);
  localparam logic [AW-1:0] LAST_PTR = AW'(REG_NUM - 1);

  tbl_state_t    state, state_nxt;
  logic [AW-1:0] clr_ptr, clr_ptr_nxt;
  logic [AW:0]   nz_count;
  logic          clearing;
  logic          wr_acc;
  entry_t        wr_entry;
  entry_t        old_entry;

  // NOTE: the storage array has no reset; the clear sweep zeroes it after every reset.
  entry_t mem [REG_NUM];

  logic [NUM_RD-1:0]        rd_valid_w;
  logic [NUM_RD*LEN_W-1:0]  rd_len_w;
  logic [NUM_RD*CODE_W-1:0] rd_code_w;

  assign clearing  = (state == CLEAR);
  assign wr_acc    = (state == IDLE) && bus.wr_en && !bus.clr_start;
  assign wr_entry  = '{len: bus.wr_len, code: bus.wr_code};
  assign old_entry = mem[bus.wr_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      IDLE: begin
        if (bus.clr_start) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      CLEAR: begin
        if (bus.clr_start) begin
          clr_ptr_nxt = '0;
        end else if (clr_ptr == LAST_PTR) begin
          state_nxt   = IDLE;
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + AW'(1);
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  // Single write port shared by the sweep and the code builder.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_ptr] <= '0;
    end else if (wr_acc) begin
      mem[bus.wr_addr] <= wr_entry;
    end
  end

  // Track transitions across len == 0 so the count never needs a rescan.
  always_ff @(posedge clk) begin
    if (rst || clearing || bus.clr_start) begin
      nz_count <= '0;
    end else if (wr_acc) begin
      if ((old_entry.len == '0) && (wr_entry.len != '0)) begin
        nz_count <= nz_count + (AW+1)'(1);
      end else if ((old_entry.len != '0) && (wr_entry.len == '0)) begin
        nz_count <= nz_count - (AW+1)'(1);
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] addr;
    entry_t        rd_data;

    assign addr = bus.rd_addr[p*AW +: AW];

    huff_tbl_rd_port #(.AW(AW)) u_port (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (bus.rd_en[p]),
      .rd_addr   (addr),
      .mem_entry (mem[addr]),
      .clearing  (clearing),
      .wr_acc    (wr_acc),
      .wr_addr   (bus.wr_addr),
      .wr_entry  (wr_entry),
      .rd_valid  (rd_valid_w[p]),
      .rd_data   (rd_data)
    );

    assign rd_len_w[p*LEN_W +: LEN_W]    = rd_data.len;
    assign rd_code_w[p*CODE_W +: CODE_W] = rd_data.code;
  end

  assign bus.busy     = clearing;
  assign bus.rd_valid = rd_valid_w;
  assign bus.rd_len   = rd_len_w;
  assign bus.rd_code  = rd_code_w;
  assign bus.nz_count = nz_count;

endmodule

// File: tb/tb_huff_code_table.sv
// Bench for huff_code_table: directed vector table, clear/reset sweep
// sequences and random traffic against a whole-table behavioural model.
module tb_huff_code_table;

  localparam int REG_NUM = 256;
  localparam int NUM_RD  = 2;
  localparam int AW      = 8;
  localparam int LEN_W   = 6;
  localparam int CODE_W  = 16;

  logic clk;
  logic rst;

  huff_code_table_if #(.AW(AW), .LEN_W(LEN_W), .CODE_W(CODE_W), .NUM_RD(NUM_RD)) bus ();

  huff_code_table #(.REG_NUM(REG_NUM), .NUM_RD(NUM_RD), .LEN_W(LEN_W), .CODE_W(CODE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the whole table plus the number of sweep cycles left.
  logic [LEN_W-1:0]  m_len  [REG_NUM];
  logic [CODE_W-1:0] m_code [REG_NUM];
  int                clear_left;
  logic              exp_v    [NUM_RD];
  logic [LEN_W-1:0]  exp_len  [NUM_RD];
  logic [CODE_W-1:0] exp_code [NUM_RD];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_nz();
    int n = 0;
    for (int i = 0; i < REG_NUM; i++) if (m_len[i] != '0) n++;
    return n;
  endfunction

  task automatic model_zero();
    for (int i = 0; i < REG_NUM; i++) begin
      m_len[i]  = '0;
      m_code[i] = '0;
    end
  endtask

  task automatic drive(input logic clr, input logic we, input logic [AW-1:0] wa,
                       input logic [LEN_W-1:0] wl, input logic [CODE_W-1:0] wc,
                       input logic [NUM_RD-1:0] re, input logic [AW-1:0] ra0,
                       input logic [AW-1:0] ra1);
    bus.clr_start = clr;
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_len    = wl;
    bus.wr_code   = wc;
    bus.rd_en     = re;
    bus.rd_addr   = {ra1, ra0};
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    logic             busy_b;
    logic             wr_ok;
    logic [AW-1:0]    a;
    @(posedge clk);
    #1;
    if (rst) begin
      clear_left = REG_NUM;
      model_zero();
      for (int p = 0; p < NUM_RD; p++) begin
        exp_v[p]    = 1'b0;
        exp_len[p]  = '0;
        exp_code[p] = '0;
      end
    end else begin
      busy_b = (clear_left > 0);
      wr_ok  = !busy_b && bus.wr_en && !bus.clr_start;
      for (int p = 0; p < NUM_RD; p++) begin
        exp_v[p] = bus.rd_en[p];
        if (bus.rd_en[p]) begin
          a = bus.rd_addr[p*AW +: AW];
          if (busy_b) begin
            exp_len[p]  = '0;
            exp_code[p] = '0;
          end else if (wr_ok && a == bus.wr_addr) begin
            exp_len[p]  = bus.wr_len;
            exp_code[p] = bus.wr_code;
          end else begin
            exp_len[p]  = m_len[a];
            exp_code[p] = m_code[a];
          end
        end
      end
      if (bus.clr_start) begin
        clear_left = REG_NUM;
        model_zero();
      end else if (busy_b) begin
        clear_left--;
      end else if (bus.wr_en) begin
        m_len[bus.wr_addr]  = bus.wr_len;
        m_code[bus.wr_addr] = bus.wr_code;
      end
    end
    check("busy", 32'(bus.busy), 32'(clear_left > 0));
    check("nz_count", 32'(bus.nz_count), 32'(model_nz()));
    for (int p = 0; p < NUM_RD; p++) begin
      check($sformatf("rd_valid[%0d]", p), 32'(bus.rd_valid[p]), 32'(exp_v[p]));
      check($sformatf("rd_len[%0d]", p), 32'(bus.rd_len[p*LEN_W +: LEN_W]), 32'(exp_len[p]));
      check($sformatf("rd_code[%0d]", p), 32'(bus.rd_code[p*CODE_W +: CODE_W]), 32'(exp_code[p]));
    end
  endtask

  // Called right after the edge that starts a sweep; the first tick uses the caller's inputs.
  task automatic count_busy(input string name);
    int n = 0;
    while (bus.busy === 1'b1 && n < 1000) begin
      n++;
      tick();
      idle();
    end
    check(name, 32'(n), 32'(REG_NUM));
  endtask

  typedef struct {
    logic              clr;
    logic              we;
    logic [AW-1:0]     wa;
    logic [LEN_W-1:0]  wl;
    logic [CODE_W-1:0] wc;
    logic [1:0]        re;
    logic [AW-1:0]     ra0;
    logic [AW-1:0]     ra1;
    logic [AW:0]       e_nz;
    logic [1:0]        e_v;
    logic [LEN_W-1:0]  e_len0;
    logic [CODE_W-1:0] e_code0;
    logic [LEN_W-1:0]  e_len1;
    logic [CODE_W-1:0] e_code1;
  } vec_t;

  vec_t vecs [10];

  initial begin
    //          clr we  wa     wl  wc       re     ra0    ra1    nz  v      len0 code0    len1 code1
    vecs[0] = '{1'b0, 1'b1, 8'h41, 6'd3, 16'h0005, 2'b00, 8'h00, 8'h00, 9'd1, 2'b00, 6'd0, 16'h0000, 6'd0, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 6'd0, 16'h0000, 2'b01, 8'h41, 8'h00, 9'd1, 2'b01, 6'd3, 16'h0005, 6'd0, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 8'h10, 6'd7, 16'h003A, 2'b11, 8'h10, 8'h10, 9'd2, 2'b11, 6'd7, 16'h003A, 6'd7, 16'h003A};
    vecs[3] = '{1'b0, 1'b1, 8'h10, 6'd0, 16'h0000, 2'b00, 8'h00, 8'h00, 9'd1, 2'b00, 6'd7, 16'h003A, 6'd7, 16'h003A};
    vecs[4] = '{1'b0, 1'b1, 8'h41, 6'd0, 16'h0000, 2'b00, 8'h00, 8'h00, 9'd0, 2'b00, 6'd7, 16'h003A, 6'd7, 16'h003A};
    vecs[5] = '{1'b0, 1'b1, 8'h41, 6'd4, 16'h0009, 2'b00, 8'h00, 8'h00, 9'd1, 2'b00, 6'd7, 16'h003A, 6'd7, 16'h003A};
    vecs[6] = '{1'b0, 1'b1, 8'h41, 6'd4, 16'h000A, 2'b00, 8'h00, 8'h00, 9'd1, 2'b00, 6'd7, 16'h003A, 6'd7, 16'h003A};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 6'd0, 16'h0000, 2'b11, 8'h10, 8'h41, 9'd1, 2'b11, 6'd0, 16'h0000, 6'd4, 16'h000A};
    vecs[8] = '{1'b0, 1'b1, 8'h41, 6'd5, 16'h001F, 2'b11, 8'h41, 8'h10, 9'd1, 2'b11, 6'd5, 16'h001F, 6'd0, 16'h0000};
    vecs[9] = '{1'b0, 1'b0, 8'h00, 6'd0, 16'h0000, 2'b10, 8'h00, 8'h41, 9'd1, 2'b10, 6'd5, 16'h001F, 6'd5, 16'h001F};

    rst = 1'b1;
    idle();
    clear_left = REG_NUM;
    model_zero();
    tick();
    tick();
    check("reset rd_valid", 32'(bus.rd_valid), 32'd0);
    check("reset nz_count", 32'(bus.nz_count), 32'd0);
    rst = 1'b0;
    count_busy("reset sweep length");

    drive(1'b0, 1'b0, '0, '0, '0, 2'b11, 8'h00, 8'hFF);
    tick();
    check("after sweep rd_valid", 32'(bus.rd_valid), 32'h3);
    check("after sweep len/code", 32'({bus.rd_len, bus.rd_code}), 32'd0);
    check("after sweep nz_count", 32'(bus.nz_count), 32'd0);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].clr, vecs[i].we, vecs[i].wa, vecs[i].wl, vecs[i].wc,
            vecs[i].re, vecs[i].ra0, vecs[i].ra1);
      tick();
      check($sformatf("vec%0d nz_count", i), 32'(bus.nz_count), 32'(vecs[i].e_nz));
      check($sformatf("vec%0d rd_valid", i), 32'(bus.rd_valid), 32'(vecs[i].e_v));
      check($sformatf("vec%0d len0", i), 32'(bus.rd_len[0 +: LEN_W]), 32'(vecs[i].e_len0));
      check($sformatf("vec%0d code0", i), 32'(bus.rd_code[0 +: CODE_W]), 32'(vecs[i].e_code0));
      check($sformatf("vec%0d len1", i), 32'(bus.rd_len[LEN_W +: LEN_W]), 32'(vecs[i].e_len1));
      check($sformatf("vec%0d code1", i), 32'(bus.rd_code[CODE_W +: CODE_W]), 32'(vecs[i].e_code1));
    end

    // Fill ten more symbols, then clear; a write during the sweep must be lost.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, AW'(8'h80 + i), LEN_W'(i + 1), CODE_W'(i), 2'b00, '0, '0);
      tick();
    end
    check("fill nz_count", 32'(bus.nz_count), 32'd11);
    drive(1'b1, 1'b0, '0, '0, '0, 2'b00, '0, '0);
    tick();
    check("clr_start nz_count", 32'(bus.nz_count), 32'd0);
    check("clr_start busy", 32'(bus.busy), 32'd1);
    drive(1'b0, 1'b1, 8'h20, 6'd5, 16'h0077, 2'b00, '0, '0);
    count_busy("clr sweep length");
    drive(1'b0, 1'b0, '0, '0, '0, 2'b11, 8'h20, 8'h80);
    tick();
    check("dropped write len/code", 32'({bus.rd_len, bus.rd_code}), 32'd0);
    check("dropped write nz_count", 32'(bus.nz_count), 32'd0);

    // Restart the sweep from clr_ptr=100, then again via reset.
    drive(1'b1, 1'b0, '0, '0, '0, 2'b00, '0, '0);
    tick();
    idle();
    repeat (100) tick();
    drive(1'b1, 1'b0, '0, '0, '0, 2'b00, '0, '0);
    tick();
    idle();
    count_busy("restart sweep length");

    drive(1'b1, 1'b0, '0, '0, '0, 2'b00, '0, '0);
    tick();
    idle();
    repeat (100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy("reset mid-sweep length");

    // Random traffic over a narrow address window so bypass hits are frequent.
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] wa, ra0, ra1;
      wa  = AW'($urandom_range(0, 15));
      ra0 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      drive(($urandom_range(0, 399) == 0),
            ($urandom_range(0, 1) == 1),
            wa,
            ($urandom_range(0, 3) == 0) ? '0 : LEN_W'($urandom),
            CODE_W'($urandom),
            NUM_RD'($urandom),
            ra0, ra1);
      rst = ($urandom_range(0, 1499) == 0);
      tick();
    end
    rst = 1'b0;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
